// File: rtl/blowfish128_pkg.sv
// Shared types and sizes for the Blowfish-128 round scheduler.
package blowfish128_pkg;
  localparam int NUM_ROUNDS = 16;
  localparam int P_ENTRIES  = 18;
  localparam int HALF_W     = 64;
  localparam int BLOCK_W    = 128;

  typedef enum logic [3:0] {
    S_IDLE, S_PRD, S_PXOR, S_FREQ, S_FWAIT, S_K16RD, S_K16X, S_K17X, S_DONE
  } sched_state_t;
endpackage

// File: rtl/blowfish128_round_sched_if.sv
// Block I/O handshake between the cipher core front end and the round scheduler.
interface blowfish128_round_sched_if;
  import blowfish128_pkg::*;

  logic               InValid;
  logic               InReady;
  logic [BLOCK_W-1:0] InData;
  logic               Decrypt;
  logic               OutValid;
  logic               OutReady;
  logic [BLOCK_W-1:0] OutData;

  modport slave  (input  InValid, InData, Decrypt, OutReady,
                  output InReady, OutValid, OutData);
  modport master (output InValid, InData, Decrypt, OutReady,
                  input  InReady, OutValid, OutData);
endinterface

// File: rtl/blowfish128_pidx_map.sv
// Maps a logical P-array index to the physical entry: identity for encrypt, mirrored for decrypt.
module blowfish128_pidx_map
  import blowfish128_pkg::*;
(
  input  logic [4:0] idx,
  input  logic       decrypt,
  output logic [4:0] pidx
);
  always_comb begin
    pidx = decrypt ? (5'(P_ENTRIES - 1) - idx) : idx;
  end
endmodule

// File: rtl/blowfish128_round_sched.sv
// Blowfish-128 round scheduler: runs 16 Feistel rounds on 64-bit halves using an external
// pipelined F-function and a registered-read P-array.
module blowfish128_round_sched
  import blowfish128_pkg::*;
#(
  parameter int F_TIMEOUT = 64
) (
  input  logic                      Clk,
  input  logic                      Rst,
  blowfish128_round_sched_if.slave  io,
  output logic [4:0]                PIdx,
  input  logic [HALF_W-1:0]         PData,
  output logic                      F_Enable,
  output logic [HALF_W-1:0]         F_X,
  input  logic [HALF_W-1:0]         F_Y,
  input  logic                      F_Valid,
  output logic                      Busy,
  output logic [3:0]                Round,
  output logic                      Err
);
  localparam int TMO_W = (F_TIMEOUT > 2) ? $clog2(F_TIMEOUT) : 1;

  sched_state_t       state_q, state_d;
  logic [HALF_W-1:0]  xl_q, xl_d, xr_q, xr_d, fx_q, fx_d;
  logic [BLOCK_W-1:0] outdata_q, outdata_d;
  logic [3:0]         round_q, round_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [4:0]         pidx_q, pidx_d, map_idx, map_out;
  logic               dec_q, dec_d, err_q, err_d, fen_q, fen_d;
  logic               inready_q, inready_d, outvalid_q, outvalid_d, busy_q, busy_d;
  logic               map_dec, rd_en;

  blowfish128_pidx_map u_pidx_map (
    .idx     (map_idx),
    .decrypt (map_dec),
    .pidx    (map_out)
  );

  // Outputs are registered from the next state, so each is valid in the cycle its state is entered.
  always_comb begin
    state_d   = state_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    fx_d      = fx_q;
    dec_d     = dec_q;
    round_d   = round_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    outdata_d = outdata_q;
    fen_d     = 1'b0;
    map_idx   = 5'd0;
    map_dec   = dec_q;
    rd_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (io.InValid && inready_q) begin
          xl_d    = io.InData[BLOCK_W-1:HALF_W];
          xr_d    = io.InData[HALF_W-1:0];
          dec_d   = io.Decrypt;
          round_d = 4'd0;
          err_d   = 1'b0;
          map_dec = io.Decrypt;
          rd_en   = 1'b1;
          state_d = S_PRD;
        end
      end
      S_PRD: state_d = S_PXOR;
      S_PXOR: begin
        xl_d    = xl_q ^ PData;
        fx_d    = xl_q ^ PData;
        fen_d   = 1'b1;
        state_d = S_FREQ;
      end
      S_FREQ: begin
        tmo_d   = '0;
        state_d = S_FWAIT;
      end
      S_FWAIT: begin
        if (F_Valid) begin
          fx_d  = '0;
          rd_en = 1'b1;
          if (round_q == 4'(NUM_ROUNDS - 1)) begin
            // Last round leaves the halves unswapped.
            xr_d    = xr_q ^ F_Y;
            map_idx = 5'(NUM_ROUNDS);
            state_d = S_K16RD;
          end else begin
            xl_d    = xr_q ^ F_Y;
            xr_d    = xl_q;
            round_d = round_q + 4'd1;
            map_idx = {1'b0, round_q + 4'd1};
            state_d = S_PRD;
          end
        end else if (tmo_q == TMO_W'(F_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          fx_d    = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_K16RD: begin
        map_idx = 5'(NUM_ROUNDS + 1);
        rd_en   = 1'b1;
        state_d = S_K16X;
      end
      S_K16X: begin
        xr_d    = xr_q ^ PData;
        state_d = S_K17X;
      end
      S_K17X: begin
        xl_d      = xl_q ^ PData;
        outdata_d = {xl_q ^ PData, xr_q};
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (io.OutReady) begin
          outdata_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pidx_d     = rd_en ? map_out : 5'd0;
    inready_d  = (state_d == S_IDLE);
    outvalid_d = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      xl_q       <= '0;
      xr_q       <= '0;
      fx_q       <= '0;
      dec_q      <= 1'b0;
      round_q    <= 4'd0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      outdata_q  <= '0;
      fen_q      <= 1'b0;
      pidx_q     <= 5'd0;
      inready_q  <= 1'b0;
      outvalid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      xl_q       <= xl_d;
      xr_q       <= xr_d;
      fx_q       <= fx_d;
      dec_q      <= dec_d;
      round_q    <= round_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      outdata_q  <= outdata_d;
      fen_q      <= fen_d;
      pidx_q     <= pidx_d;
      inready_q  <= inready_d;
      outvalid_q <= outvalid_d;
      busy_q     <= busy_d;
    end
  end

  assign io.InReady  = inready_q;
  assign io.OutValid = outvalid_q;
  assign io.OutData  = outdata_q;
  assign PIdx        = pidx_q;
  assign F_Enable    = fen_q;
  assign F_X         = fx_q;
  assign Busy        = busy_q;
  assign Round       = round_q;
  assign Err         = err_q;
endmodule
